// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Drives PS2_CLK/PS2_DAT open-drain via oe pins; reports done/NACK/timeouts.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int TM1 = (INHIBIT_CYCLES > START_TIMEOUT) ?
                       INHIBIT_CYCLES : START_TIMEOUT;
  localparam int TMAX = (TM1 > XFER_TIMEOUT) ? TM1 : XFER_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_INH   = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] T_START = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] T_XFER  = TW'(XFER_TIMEOUT - 1);

  localparam logic [1:0] E_NORESP = 2'b01;
  localparam logic [1:0] E_XFER   = 2'b10;
  localparam logic [1:0] E_NACK   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    WAIT_FIRST,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t        state, state_d;
  logic [TW-1:0] tmr, tmr_d;
  logic [9:0]    frame, frame_d;
  logic [3:0]    cnt, cnt_d;
  logic          done_d, err_d;
  logic [1:0]    code_d;

  logic [1:0] clk_sync, dat_sync;
  logic       clk_q;
  logic       clk_s, dat_s, fall;
  logic       xfer_to;

  assign clk_s   = clk_sync[1];
  assign dat_s   = dat_sync[1];
  assign fall    = clk_q & ~clk_s;
  assign xfer_to = (tmr == T_XFER);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_q    <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      clk_q    <= clk_sync[1];
    end
  end

  always_comb begin
    state_d = state;
    tmr_d   = (&tmr) ? tmr : tmr + TW'(1);
    frame_d = frame;
    cnt_d   = cnt;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = err_code;
    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          state_d = INHIBIT;
          tmr_d   = '0;
          frame_d = {1'b1, ~^tx_data, tx_data};
          code_d  = 2'b00;
        end
      end
      INHIBIT: begin
        if (tmr == T_INH) begin
          state_d = REQ;
        end
      end
      REQ: begin
        state_d = WAIT_FIRST;
        tmr_d   = '0;
      end
      WAIT_FIRST: begin
        if (fall) begin
          state_d = SHIFT;
          cnt_d   = 4'd1;
          tmr_d   = '0;
        end else if (tmr == T_START) begin
          state_d = IDLE;
          err_d   = 1'b1;
          code_d  = E_NORESP;
        end
      end
      SHIFT: begin
        if (fall) begin
          frame_d = {1'b1, frame[9:1]};
          cnt_d   = cnt + 4'd1;
          if (cnt == 4'd9) begin
            state_d = ACK;
          end
        end else if (xfer_to) begin
          state_d = IDLE;
          err_d   = 1'b1;
          code_d  = E_XFER;
        end
      end
      ACK: begin
        if (fall) begin
          if (!dat_s) begin
            state_d = WAIT_IDLE;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
            code_d  = E_NACK;
          end
        end else if (xfer_to) begin
          state_d = IDLE;
          err_d   = 1'b1;
          code_d  = E_XFER;
        end
      end
      WAIT_IDLE: begin
        if (clk_s && dat_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (xfer_to) begin
          state_d = IDLE;
          err_d   = 1'b1;
          code_d  = E_XFER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tmr      <= '0;
      frame    <= '1;
      cnt      <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= 2'b00;
    end else begin
      state    <= state_d;
      tmr      <= tmr_d;
      frame    <= frame_d;
      cnt      <= cnt_d;
      done     <= done_d;
      error    <= err_d;
      err_code <= code_d;
    end
  end

  // Line drive decodes from state so reset releases both pins at once.
  always_comb begin
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    unique case (1'b1)
      (state == INHIBIT): ps2_clk_oe = 1'b1;
      (state == REQ): begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = 1'b1;
      end
      (state == WAIT_FIRST): ps2_dat_oe = 1'b1;
      (state == SHIFT): ps2_dat_oe = ~frame[0];
      default: ;
    endcase
  end

  assign busy       = (state != IDLE);
  assign rx_inhibit = busy;
  assign tx_ready   = (state == IDLE);

endmodule
